move_planner: RTL and testbench

MOVE_PLANNER -- requirements
Module: move_planner

---
 rtl/move_cmd_if.sv | 12 +
 rtl/move_planner.sv | 110 +++++++++++
 tb/tb_move_planner.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/move_cmd_if.sv
// Command channel from the move planner to the downstream walker.
// The master drives a direction/step command qualified by cmd_valid;
// the slave accepts it by raising cmd_ready in the same cycle.
interface move_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] dir;
    logic [1:0] steps;

    modport master (output cmd_valid, output dir, output steps, input cmd_ready);
    modport slave  (input cmd_valid, input dir, input steps, output cmd_ready);
endinterface

// File: rtl/move_planner.sv
// move_planner: walks a tracked (x,y) position on a 16x16 grid toward a
// captured target, one axis at a time, issuing commands of 1..3 steps.
// dir encoding: 00 = +x, 01 = -x, 10 = +y, 11 = -y.
// Build option: define MOVE_PLANNER_Y_FIRST_EN to move along y before x;
// by default x is moved first. Handshake and timing are the same either way.
module move_planner (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  target_x,
    input  logic [3:0]  target_y,
    move_cmd_if.master  cmd,
    output logic        busy,
    output logic        done,
    output logic [3:0]  cur_x,
    output logic [3:0]  cur_y
);

`ifdef MOVE_PLANNER_Y_FIRST_EN
    localparam logic Y_FIRST = 1'b1;
`else
    localparam logic Y_FIRST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MOVE_A, MOVE_B, DONE} state_t;

    state_t state, state_nx;

    logic [3:0]        tgt_x, tgt_y;
    logic              in_move;
    logic              axis_y;
    logic [3:0]        pos_axis, tgt_axis;
    logic signed [4:0] gap;
    logic [4:0]        gap_mag;
    logic              accept;
    logic              closes;
    logic [3:0]        step_ext;

    // Magnitude of a signed axis gap (range -15..15).
    function automatic logic [4:0] abs_gap(input logic signed [4:0] g);
        logic signed [4:0] neg;
        neg = -g;
        return g[4] ? $unsigned(neg) : $unsigned(g);
    endfunction

    // Step count saturates at 3; never exceeds the remaining gap.
    function automatic logic [1:0] sat_steps(input logic [4:0] mag);
        return (mag > 5'd3) ? 2'd3 : mag[1:0];
    endfunction

    // Active axis, remaining gap and the command presented to the walker.
    always_comb begin
        in_move  = (state == MOVE_A) || (state == MOVE_B);
        axis_y   = (state == MOVE_A) ? Y_FIRST : ~Y_FIRST;
        pos_axis = axis_y ? cur_y : cur_x;
        tgt_axis = axis_y ? tgt_y : tgt_x;
        gap      = $signed({1'b0, tgt_axis}) - $signed({1'b0, pos_axis});
        gap_mag  = abs_gap(gap);

        cmd.cmd_valid = in_move && (gap != 5'sd0);
        cmd.dir       = cmd.cmd_valid ? {axis_y, gap[4]} : 2'b00;
        cmd.steps     = cmd.cmd_valid ? sat_steps(gap_mag) : 2'b00;

        accept   = cmd.cmd_valid && cmd.cmd_ready;
        // Axis finished: either already there (one-cycle bubble) or the
        // accepted command covers exactly the remaining gap.
        closes   = (gap == 5'sd0) || (accept && ({3'b000, cmd.steps} == gap_mag));
        step_ext = {2'b00, cmd.steps};
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nx = state;
        busy     = in_move;
        done     = (state == DONE);
        case (state)
            IDLE:    if (start)  state_nx = MOVE_A;
            MOVE_A:  if (closes) state_nx = MOVE_B;
            MOVE_B:  if (closes) state_nx = DONE;
            DONE:                state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Target capture in IDLE and position update on each accepted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_x <= 4'd0;
            tgt_y <= 4'd0;
            cur_x <= 4'd0;
            cur_y <= 4'd0;
        end else begin
            if (state == IDLE && start) begin
                tgt_x <= target_x;
                tgt_y <= target_y;
            end
            if (accept) begin
                if (axis_y) cur_y <= gap[4] ? cur_y - step_ext : cur_y + step_ext;
                else        cur_x <= gap[4] ? cur_x - step_ext : cur_x + step_ext;
            end
        end
    end

endmodule

// File: tb/tb_move_planner.sv
// Testbench for move_planner: directed moves plus randomized targets and
// walker back-pressure, checked against a grid-walk reference model.
module tb_move_planner;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] target_x, target_y;
    logic       busy, done;
    logic [3:0] cur_x, cur_y;

    move_cmd_if cmd_bus();

    move_planner dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .target_x (target_x),
        .target_y (target_y),
        .cmd      (cmd_bus),
        .busy     (busy),
        .done     (done),
        .cur_x    (cur_x),
        .cur_y    (cur_y)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: tracked position and expected command list {dir,steps}.
    int         mdl_x = 0;
    int         mdl_y = 0;
    logic [3:0] exp_q[$];

    // Plan one axis: greedy chunks of at most 3 toward the target.
    task automatic plan_axis(input bit y_axis, input int from, input int to, output int n);
        int pos, d, s;
        pos = from;
        n = 0;
        while (pos != to) begin
            d = to - pos;
            s = (d < 0) ? -d : d;
            if (s > 3) s = 3;
            exp_q.push_back({y_axis, (d < 0), 2'(s)});
            pos = (d < 0) ? pos - s : pos + s;
            n++;
        end
    endtask

    // Drive one move and follow it cycle by cycle against the model.
    task automatic run_move(input logic [3:0] tx, input logic [3:0] ty,
                            input int stall, input bit rnd);
        int na, nb, exp_done, cyc, s;
        bit acc, seen_done;
        logic [3:0] w;
        exp_q.delete();
`ifdef MOVE_PLANNER_Y_FIRST_EN
        plan_axis(1'b1, mdl_y, int'(ty), na);
        plan_axis(1'b0, mdl_x, int'(tx), nb);
`else
        plan_axis(1'b0, mdl_x, int'(tx), na);
        plan_axis(1'b1, mdl_y, int'(ty), nb);
`endif
        exp_done = ((na == 0) ? 1 : na) + ((nb == 0) ? 1 : nb) + 1 + stall;

        @(posedge clk); #1;
        start = 1'b1; target_x = tx; target_y = ty;
        cmd_bus.cmd_ready = 1'b0;
        @(posedge clk); #1;
        cyc = 1;
        seen_done = 1'b0;
        while (!seen_done && cyc <= 100) begin
            if (cyc <= stall)  cmd_bus.cmd_ready = 1'b0;
            else if (rnd)      cmd_bus.cmd_ready = ($urandom_range(0, 99) < 70);
            else               cmd_bus.cmd_ready = 1'b1;
            // start and target changes while busy must be ignored
            start    = 1'($urandom_range(0, 1));
            target_x = 4'($urandom);
            target_y = 4'($urandom);
            @(negedge clk);
            checks++;
            if (int'(cur_x) != mdl_x || int'(cur_y) != mdl_y) begin
                errors++;
                $display("FAIL pos: cycle %0d got (%0d,%0d) want (%0d,%0d)", cyc, cur_x, cur_y, mdl_x, mdl_y);
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                checks++;
                if (busy !== 1'b0 || cmd_bus.cmd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL done_state: busy=%b valid=%b want 0/0", busy, cmd_bus.cmd_valid);
                end
                checks++;
                if (exp_q.size() != 0 || cur_x !== tx || cur_y !== ty) begin
                    errors++;
                    $display("FAIL arrive: got (%0d,%0d) left %0d cmds want (%0d,%0d) 0 cmds", cur_x, cur_y, exp_q.size(), tx, ty);
                end
                if (!rnd) begin
                    checks++;
                    if (cyc != exp_done) begin
                        errors++;
                        $display("FAIL done_cycle: got %0d want %0d", cyc, exp_done);
                    end
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy: cycle %0d got %b want 1", cyc, busy);
                end
                if (cmd_bus.cmd_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL cmd: got %b/%0d want no command", cmd_bus.dir, cmd_bus.steps);
                    end else if ({cmd_bus.dir, cmd_bus.steps} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL cmd: cycle %0d got %b/%0d want %b/%0d", cyc,
                                 cmd_bus.dir, cmd_bus.steps, exp_q[0][3:2], exp_q[0][1:0]);
                    end
                end
            end
            acc = (cmd_bus.cmd_valid === 1'b1) && cmd_bus.cmd_ready;
            @(posedge clk); #1;
            if (acc && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                s = int'(w[1:0]);
                if (w[3]) mdl_y = w[2] ? mdl_y - s : mdl_y + s;
                else      mdl_x = w[2] ? mdl_x - s : mdl_x + s;
            end
            cyc++;
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within %0d cycles want done", cyc);
        end
        start = 1'b0;
        cmd_bus.cmd_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b valid=%b want 0/0/0", done, busy, cmd_bus.cmd_valid);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (cmd_bus.cmd_valid !== 1'b0 || cmd_bus.dir !== 2'b00 || cmd_bus.steps !== 2'b00 ||
            busy !== 1'b0 || done !== 1'b0 || cur_x !== 4'd0 || cur_y !== 4'd0) begin
            errors++;
            $display("FAIL %s: valid=%b dir=%b steps=%0d busy=%b done=%b cur=(%0d,%0d) want all 0",
                     tag, cmd_bus.cmd_valid, cmd_bus.dir, cmd_bus.steps, busy, done, cur_x, cur_y);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; target_x = 4'd0; target_y = 4'd0;
        cmd_bus.cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_x = 0; mdl_y = 0;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_directed_moves();
`ifdef MOVE_PLANNER_Y_FIRST_EN
        run_move(4'd5, 4'd9, 0, 1'b0);
        run_move(4'd5, 4'd2, 0, 1'b0);
`else
        run_move(4'd7, 4'd2, 0, 1'b0);
        run_move(4'd0, 4'd2, 0, 1'b0);
`endif
    endtask

    task automatic test_same_target();
        run_move(4'(mdl_x), 4'(mdl_y), 0, 1'b0);
    endtask

    task automatic test_stall();
        run_move(4'd9, 4'd11, 4, 1'b0);
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        start = 1'b1; target_x = 4'd0; target_y = 4'd0;
        cmd_bus.cmd_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || cmd_bus.cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy: busy=%b valid=%b want 1/1", busy, cmd_bus.cmd_valid);
        end
        #2 reset = 1'b1;
        #1 check_all_zero("reset_async");
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset_hold");
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_x = 0; mdl_y = 0;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("post_reset");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_move(4'($urandom), 4'($urandom), 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_move(4'($urandom), 4'($urandom), 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed_moves();
        test_same_target();
        test_stall();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
